reg_dump_reader: RTL and testbench

- Read-port initiator for the 16x32 processor register bank.
- On a start pulse, walks registers 0..NREGS-1 through both read ports (A1 = even index, A2 = odd index), two registers per read cycle.
- Serialises the values onto a 32-bit valid/ready stream for the debug/host path, so key and state registers of the image decryptor can be inspected after a run.
- The bank's read ports are combinational; this block drives addresses and samples RD1/RD2 on the next clock edge.

---
 rtl/reg_dump_pkg.sv | 17 +
 rtl/reg_dump_reader.sv | 161 ++++++++++++++++
 tb/tb_reg_dump_reader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared states and constants for the register dump reader
package reg_dump_pkg;

    localparam int REG_AW = 4;
    localparam int REG_DW = 32;
    localparam int PC_REG = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        SEND_LO  = 3'd2,
        SEND_HI  = 3'd3,
        SEND_CHK = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register bank in pairs and streams the words out (optional REG_DUMP_CHECKSUM_EN)
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] A1,
    output logic [AW-1:0] A2,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] ptr;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          last_pair;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DW-1:0] acc;
`endif

    // Both read ports are addressed straight from the pair pointer
    assign A1        = ptr;
    assign A2        = ptr + AW'(1);
    assign last_pair = (ptr == AW'(NREGS - 2));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream outputs; out_valid is a pure function of state
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                state_nxt = SEND_LO;
            end
            SEND_LO: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = lo;
                if (out_ready) begin
                    state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = hi;
`ifdef REG_DUMP_CHECKSUM_EN
                out_last  = 1'b0;
                if (out_ready) begin
                    state_nxt = last_pair ? SEND_CHK : READ;
                end
`else
                out_last  = last_pair;
                if (out_ready) begin
                    state_nxt = last_pair ? DONE : READ;
                end
`endif
            end
            SEND_CHK: begin
`ifdef REG_DUMP_CHECKSUM_EN
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = acc;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = DONE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pair pointer, snapshot buffers and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            lo  <= '0;
            hi  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                        acc <= '0;
`endif
                    end
                end
                READ: begin
                    // Both halves of a pair come from the same bank cycle
                    lo <= RD1;
                    hi <= RD2;
                end
                SEND_LO: begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (out_ready) begin
                        acc <= acc ^ lo;
                    end
`endif
                end
                SEND_HI: begin
                    if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        acc <= acc ^ hi;
`endif
                        if (!last_pair) begin
                            ptr <= ptr + AW'(2);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - directed table-driven bench for reg_dump_reader
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NW       = 17;
    localparam int NW4      = 5;
    localparam int BUSY_EXP = 25;
`else
    localparam int NW       = 16;
    localparam int NW4      = 4;
    localparam int BUSY_EXP = 24;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic        start4;
    logic        busy4;
    logic        done4;
    logic [3:0]  a1_4;
    logic [3:0]  a2_4;
    logic [31:0] rd1_4;
    logic [31:0] rd2_4;
    logic [31:0] data4;
    logic        valid4;
    logic        ready4;
    logic        last4;

    logic [31:0] bank [16];
    logic [31:0] bank4 [16];

    assign RD1   = bank[A1];
    assign RD2   = bank[A2];
    assign rd1_4 = bank4[a1_4];
    assign rd2_4 = bank4[a2_4];

    reg_dump_reader u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    reg_dump_reader #(.NREGS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .busy      (busy4),
        .done      (done4),
        .A1        (a1_4),
        .A2        (a2_4),
        .RD1       (rd1_4),
        .RD2       (rd2_4),
        .out_data  (data4),
        .out_valid (valid4),
        .out_ready (ready4),
        .out_last  (last4)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] q_data [$];
    bit          q_last [$];
    int          busy_cyc;
    int          done_cnt;
    bit          pv;
    bit          pr;
    logic [31:0] pd;

    logic [31:0] q4_data [$];
    bit          q4_last [$];
    int          done4_cnt;
    int          n_at_done4;
    logic [3:0]  max_a1;
    logic [3:0]  max_a2;

    logic [31:0] exp_w [17];
    bit          exp_l [17];
    logic [31:0] exp4_w [5];
    bit          exp4_l [5];

    typedef struct {
        string name;
        int    stall_at;
        int    stall_len;
        int    start_at1;
        int    start_at2;
        int    busy_exp;
    } case_t;

    case_t cases [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Stream monitor and handshake-rule checks for the 16-register instance
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
            end
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (!out_valid) chk("data_zero_when_idle", out_data, 32'h0);
            if (pv && !pr) begin
                chk("valid_held", {31'b0, out_valid}, 32'h1);
                chk("data_held", out_data, pd);
            end
        end
        pv = out_valid && !rst;
        pr = out_ready;
        pd = out_data;
    end

    // Stream monitor for the 4-register instance
    always @(negedge clk) begin
        if (!rst) begin
            if (valid4 && ready4) begin
                q4_data.push_back(data4);
                q4_last.push_back(last4);
            end
            if (done4) begin
                if (done4_cnt == 0) n_at_done4 = q4_data.size();
                done4_cnt++;
            end
            if (a1_4 > max_a1) max_a1 = a1_4;
            if (a2_4 > max_a2) max_a2 = a2_4;
        end
    end

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        busy_cyc = 0;
        done_cnt = 0;
    endtask

    task automatic run_case(input case_t c);
        int  stalled;
        bit  s1;
        bit  s2;
        int  n;
        clear_mon();
        stalled = 0;
        s1 = 0;
        s2 = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
            n = q_data.size();
            out_ready = 1'b1;
            start = 1'b0;
            if (n == c.stall_at && stalled < c.stall_len && out_valid) begin
                out_ready = 1'b0;
                stalled++;
                chk({c.name, "_stall_valid"}, {31'b0, out_valid}, 32'h1);
                chk({c.name, "_stall_data"}, out_data, 32'h101);
            end
            if (n == c.start_at1 && !s1) begin start = 1'b1; s1 = 1; end
            if (n == c.start_at2 && !s2) begin start = 1'b1; s2 = 1; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk({c.name, "_done_seen"}, {31'b0, done_cnt != 0}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        chk({c.name, "_word_count"}, q_data.size(), NW);
        for (int i = 0; i < NW && i < q_data.size(); i++) begin
            chk($sformatf("%s_word%0d", c.name, i), q_data[i], exp_w[i]);
            chk($sformatf("%s_last%0d", c.name, i), {31'b0, q_last[i]}, {31'b0, exp_l[i]});
        end
        chk({c.name, "_done_count"}, done_cnt, 1);
        chk({c.name, "_busy_cycles"}, busy_cyc, c.busy_exp);
    endtask

    initial begin
        logic [31:0] x;
        int          dc;
        int          guard;

        for (int i = 0; i < 16; i++) begin
            bank[i]  = (i == 15) ? 32'h0000_0040 : 32'h100 + i;
            bank4[i] = (i < 4) ? 32'hA + i : 32'h0;
        end
        x = '0;
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = bank[i];
            exp_l[i] = (i == NW - 1);
            x = x ^ bank[i];
        end
        exp_w[16] = x;
        exp_l[16] = 1'b1;
        x = '0;
        for (int i = 0; i < 4; i++) begin
            exp4_w[i] = bank4[i];
            exp4_l[i] = (i == NW4 - 1);
            x = x ^ bank4[i];
        end
        exp4_w[4] = x;
        exp4_l[4] = 1'b1;

        cases[0] = '{"full",       -1, 0, -1, -1, BUSY_EXP};
        cases[1] = '{"backpress",   1, 5, -1, -1, BUSY_EXP + 5};
        cases[2] = '{"start_busy", -1, 0,  3,  9, BUSY_EXP};

        max_a1 = '0;
        max_a2 = '0;
        done4_cnt = 0;
        n_at_done4 = -1;
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        out_ready = 1'b1;
        ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_last", {31'b0, out_last}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_A1", {28'b0, A1}, 32'h0);
        chk("rst_A2", {28'b0, A2}, 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) begin
            run_case(cases[k]);
        end

        // Reset in the middle of a dump, then restart from r0
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (q_data.size() < 3 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("midrst_reached_3", q_data.size(), 3);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_A1", {28'b0, A1}, 32'h0);
        chk("midrst_A2", {28'b0, A2}, 32'h1);
        rst = 1'b0;
        out_ready = 1'b1;
        dc = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, dc);
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("restart_done", {31'b0, done_cnt != 0}, 32'h1);
        chk("restart_count", q_data.size(), NW);
        if (q_data.size() > 0) chk("restart_first", q_data[0], 32'h100);

        // Four-register instance
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        guard = 0;
        while (done4_cnt == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("n4_word_count", q4_data.size(), NW4);
        for (int i = 0; i < NW4 && i < q4_data.size(); i++) begin
            chk($sformatf("n4_word%0d", i), q4_data[i], exp4_w[i]);
            chk($sformatf("n4_last%0d", i), {31'b0, q4_last[i]}, {31'b0, exp4_l[i]});
        end
        chk("n4_done_count", done4_cnt, 1);
        chk("n4_done_after_last", n_at_done4, NW4);
        chk("n4_max_A1", {31'b0, max_a1 <= 4'd2}, 32'h1);
        chk("n4_max_A2", {31'b0, max_a2 <= 4'd3}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
